// File: rtl/key_poll_pkg.sv
// Shared types and widths for the key poll master.
package key_poll_pkg;

  // Avalon read initiator states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } poll_state_e;

  localparam int TIMER_W   = 24;  // poll divider counter width
  localparam int LAT_W     = 3;   // read latency counter width
  localparam int DEB_CNT_W = 4;   // debounce run-length counter width

endpackage

// File: rtl/key_poll_master_debounce.sv
// Debouncer: turns strobed raw key samples into a stable level and
// one-cycle press/release pulses. A level change needs DEBOUNCE_N
// consecutive identical samples.
module key_debounce
  import key_poll_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe_i,
  input  logic raw_i,
  output logic key_state_o,
  output logic press_pulse_o,
  output logic release_pulse_o
);

  localparam logic [DEB_CNT_W-1:0] N_C = DEB_CNT_W'(DEBOUNCE_N);

  logic                 last_q, last_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 key_q, key_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;

  // Run-length tracking of the raw sample and level/pulse decision
  always_comb begin
    last_d    = last_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (strobe_i) begin
      if (raw_i == last_q) begin
        cnt_d = (cnt_q >= N_C) ? N_C : cnt_q + DEB_CNT_W'(1);
      end else begin
        cnt_d  = DEB_CNT_W'(1);
        last_d = raw_i;
      end
      if ((cnt_d == N_C) && (raw_i != key_q)) begin
        key_d     = raw_i;
        press_d   = raw_i;
        release_d = ~raw_i;
      end
    end
  end

  // Debounce state registers; last sample starts as "not pressed"
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q    <= 1'b0;
      cnt_q     <= '0;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state_o     = key_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

endmodule

// File: rtl/key_poll_master.sv
// Avalon-MM read-only initiator that periodically polls a key PIO and
// debounces the sampled bit.
// Optional: define KEY_POLL_IRQ_EN to add a sticky press interrupt
// (irq / irq_ack ports).
module key_poll_master
  import key_poll_pkg::*;
#(
  parameter int POLL_DIV     = 50000,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 2,
  parameter int KEY_ADDR     = 0,
  parameter int KEY_BIT      = 0,
  parameter int DEBOUNCE_N   = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              poll_en,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic              key_state,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              sample_strobe
`ifdef KEY_POLL_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_ack
`endif
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(READ_LATENCY);
  localparam logic               ACT_LO     = 1'(ACTIVE_LOW);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               tick;
  poll_state_e        state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               capture;
  logic               raw_pressed;
  logic               unused_readdata;

  assign avm_address     = ADDR_W'(KEY_ADDR);
  assign tick            = poll_en && (timer_q == TIMER_LAST);
  assign raw_pressed     = avm_readdata[KEY_BIT] ^ ACT_LO;
  assign sample_strobe   = capture;
  assign unused_readdata = ^avm_readdata;

  // Poll divider: free-runs while enabled (even during a read), freezes otherwise
  always_comb begin
    timer_d = timer_q;
    if (poll_en) begin
      timer_d = tick ? '0 : timer_q + TIMER_W'(1);
    end
  end

  // Read FSM: a tick only starts a read from IDLE, so late ticks are dropped
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    avm_read = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) state_d = REQ;
      end
      REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            capture = 1'b1;
            state_d = IDLE;
          end else begin
            lat_d   = LAT_W'(1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer, FSM state and latency counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      timer_q <= timer_d;
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  key_debounce #(
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_debounce (
    .clk            (clk),
    .reset_n        (reset_n),
    .strobe_i       (capture),
    .raw_i          (raw_pressed),
    .key_state_o    (key_state),
    .press_pulse_o  (press_pulse),
    .release_pulse_o(release_pulse)
  );

`ifdef KEY_POLL_IRQ_EN
  logic irq_q, irq_d;

  // Sticky press interrupt; a new press wins over a simultaneous ack
  always_comb begin
    irq_d = irq_q;
    if (press_pulse)  irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;
  end

  // Interrupt register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_key_poll_master.sv
// Self-checking bench for key_poll_master (POLL_DIV=10, READ_LATENCY=1,
// DEBOUNCE_N=4, active-low key). Honours KEY_POLL_IRQ_EN if defined.
module tb_key_poll_master;

  localparam int POLL_DIV     = 10;
  localparam int READ_LATENCY = 1;
  localparam int ADDR_W       = 2;
  localparam int KEY_ADDR     = 0;
  localparam int KEY_BIT      = 0;
  localparam int DEBOUNCE_N   = 4;
  localparam int ACTIVE_LOW   = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              poll_en;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              key_state;
  logic              press_pulse;
  logic              release_pulse;
  logic              sample_strobe;
`ifdef KEY_POLL_IRQ_EN
  logic              irq;
  logic              irq_ack;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  key_poll_master #(
    .POLL_DIV    (POLL_DIV),
    .READ_LATENCY(READ_LATENCY),
    .ADDR_W      (ADDR_W),
    .KEY_ADDR    (KEY_ADDR),
    .KEY_BIT     (KEY_BIT),
    .DEBOUNCE_N  (DEBOUNCE_N),
    .ACTIVE_LOW  (ACTIVE_LOW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .poll_en        (poll_en),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .key_state      (key_state),
    .press_pulse    (press_pulse),
    .release_pulse  (release_pulse),
    .sample_strobe  (sample_strobe)
`ifdef KEY_POLL_IRQ_EN
    ,
    .irq            (irq),
    .irq_ack        (irq_ack)
`endif
  );

  // {key data bit on the bus, expected key_state, press_pulse, release_pulse}
  typedef struct packed {
    logic data_bit;
    logic exp_key;
    logic exp_press;
    logic exp_rel;
  } vec_t;

  vec_t vecs [18] = '{
    4'b1000, 4'b1000,                     // released samples: nothing happens
    4'b0000, 4'b0000, 4'b0000, 4'b0110,   // 4th pressed sample -> press
    4'b0100,                              // still pressed, no new pulse
    4'b1100, 4'b1100, 4'b1100, 4'b1001,   // 4th released sample -> release
    4'b0000, 4'b0000, 4'b1000,            // glitch: 0,0,1
    4'b0000, 4'b0000, 4'b0000, 4'b0110    // press only on 4th 0 after the 1
  };

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_data(input logic b);
    avm_readdata          = $urandom;
    avm_readdata[KEY_BIT] = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   reads, strobes, hi, t, last_cyc, stall_pct;
    bit   found;
    logic lvl, raw, cap_now, same;
    // reference model state
    int   m_t, m_cap_at, cyc_m;
    logic m_req, m_key, m_press, m_rel, m_irq, idle, tick;
    logic hist [$];

    reset_n         = 1'b0;
    poll_en         = 1'b1;
    avm_waitrequest = 1'b0;
    drive_data(1'b1);
`ifdef KEY_POLL_IRQ_EN
    irq_ack = 1'b0;
`endif
    last_cyc = 0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    #1;
    chk("rst_read",    avm_read, 0);
    chk("rst_outputs", {key_state, press_pulse, release_pulse, sample_strobe}, 0);
    chk("rst_address", avm_address, KEY_ADDR);
`ifdef KEY_POLL_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- table-driven debounce vectors ----------------
    for (int i = 0; i < 18; i++) begin
      drive_data(vecs[i].data_bit);
      reads = 0;
      found = 0;
      t     = 0;
      while (!found && t < 2 * POLL_DIV + 5) begin
        @(negedge clk);
        #1;
        t++;
        if (avm_read) reads++;
        if (sample_strobe) found = 1;
      end
      chk("tbl_strobe_seen", found, 1);
      if (found) begin
        chk("tbl_reads_per_poll", reads, 1);
        if (i > 0) chk("tbl_poll_period", cyc - last_cyc, POLL_DIV);
        last_cyc = cyc;
        @(negedge clk);
        #1;
        chk("tbl_key_state", key_state, vecs[i].exp_key);
        chk("tbl_press",     press_pulse, vecs[i].exp_press);
        chk("tbl_release",   release_pulse, vecs[i].exp_rel);
        @(negedge clk);
        #1;
        chk("tbl_pulse_one_cycle", {press_pulse, release_pulse}, 2'b00);
      end
    end

    // ---------------- waitrequest held for 25 cycles ----------------
    avm_waitrequest = 1'b1;
    found = 0;
    t     = 0;
    while (!found && t < 2 * POLL_DIV + 5) begin
      @(negedge clk);
      #1;
      t++;
      if (avm_read) found = 1;
    end
    chk("stall_req_seen", found, 1);
    hi      = 1;
    strobes = 0;
    repeat (24) begin
      @(negedge clk);
      #1;
      if (avm_read) hi++;
      if (sample_strobe) strobes++;
    end
    chk("stall_read_held", hi, 25);
    chk("stall_no_capture", strobes, 0);
    @(negedge clk);
    avm_waitrequest = 1'b0;
    #1;
    chk("stall_accept_read", avm_read, 1);
    @(negedge clk);
    #1;
    chk("stall_capture_after_accept", {avm_read, sample_strobe}, 2'b01);
    reads = 0;
    repeat (POLL_DIV) begin
      @(negedge clk);
      #1;
      if (avm_read) reads++;
    end
    chk("stall_ticks_dropped", reads, 1);
    chk("stall_key_kept", key_state, 1);

    // ---------------- reset while in WAIT ----------------
    found = 0;
    t     = 0;
    while (!found && t < 2 * POLL_DIV + 5) begin
      @(negedge clk);
      #1;
      t++;
      if (avm_read) found = 1;
    end
    chk("rstw_req_seen", found, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstw_async_read",   avm_read, 0);
    chk("rstw_async_strobe", sample_strobe, 0);
    chk("rstw_async_key",    key_state, 0);
    strobes = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      if (sample_strobe || avm_read || press_pulse || release_pulse) strobes++;
    end
    chk("rstw_quiet_in_reset", strobes, 0);
    @(negedge clk);
    reset_n = 1'b1;
    found = 0;
    t     = 0;
    while (!found && t < 3 * POLL_DIV) begin
      @(negedge clk);
      #1;
      t++;
      if (avm_read) found = 1;
    end
    chk("rstw_resume_delay", t, POLL_DIV);

    // ---------------- randomized run against reference model ----------------
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    m_t = 0; m_cap_at = -1; cyc_m = 0;
    m_req = 0; m_key = 0; m_press = 0; m_rel = 0; m_irq = 0;
    hist.delete();
    lvl = 1'b1;
    stall_pct = 15;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) @(negedge clk);
      else       reset_n = 1'b1;
      if (i % 256 == 0) stall_pct = ($urandom_range(0, 1) != 0) ? 85 : 15;
      poll_en         = ($urandom_range(0, 9) != 0);
      avm_waitrequest = ($urandom_range(0, 99) < stall_pct);
      if ($urandom_range(0, 29) == 0) lvl = ~lvl;
      drive_data(lvl);
`ifdef KEY_POLL_IRQ_EN
      irq_ack = ($urandom_range(0, 3) == 0);
`endif
      #1;
      cap_now = (m_req && !avm_waitrequest && READ_LATENCY == 0) || (cyc_m == m_cap_at);
      chk("rand_outputs",
          {avm_read, sample_strobe, key_state, press_pulse, release_pulse},
          {m_req, cap_now, m_key, m_press, m_rel});
`ifdef KEY_POLL_IRQ_EN
      chk("rand_irq", irq, m_irq);
      m_irq = m_press ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
`endif
      // advance the model by one clock
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (cap_now) begin
        raw = avm_readdata[KEY_BIT] ^ 1'(ACTIVE_LOW);
        hist.push_back(raw);
        if (hist.size() > DEBOUNCE_N) void'(hist.pop_front());
        same = 1'b1;
        foreach (hist[k]) if (hist[k] != raw) same = 1'b0;
        if (hist.size() == DEBOUNCE_N && same && raw != m_key) begin
          m_key   = raw;
          m_press = raw;
          m_rel   = ~raw;
        end
      end
      idle = !m_req && (cyc_m > m_cap_at);
      tick = poll_en && (m_t == POLL_DIV - 1);
      if (poll_en) m_t = (m_t + 1) % POLL_DIV;
      if (m_req && !avm_waitrequest) begin
        m_req = 1'b0;
        if (READ_LATENCY > 0) m_cap_at = cyc_m + READ_LATENCY;
      end else if (idle && tick) begin
        m_req = 1'b1;
      end
      cyc_m++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/key_poll_master.md
Name: key_poll_master

Overview:
- Avalon-MM read initiator that periodically polls a single-bit input PIO slave (e.g. a key/button register) over the system interconnect.
- Debounces the sampled bit and produces a stable key level plus one-cycle press/release pulses for downstream game logic (rhythm-game note hit detection).
- Sits on the fabric side opposite the PIO responder; it issues only reads, never writes.

Parameters:
- POLL_DIV, 50000, clk cycles between poll requests (1 ms at 50 MHz); legal range 2..2^24-1.
- READ_LATENCY, 1, fixed slave read latency in cycles after the read is accepted; legal range 0..7.
- ADDR_W, 2, width of avm_address.
- KEY_ADDR, 0, word address of the data register polled.
- KEY_BIT, 0, bit index of avm_readdata that carries the key.
- DEBOUNCE_N, 4, number of consecutive identical samples required to change key_state; legal range 1..15.
- ACTIVE_LOW, 1, 1 means a raw 0 is "pressed".

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- poll_en  in  1  enables poll timer; 0 freezes timer and suppresses new reads
- avm_address  out  ADDR_W  read address, constant KEY_ADDR
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data, valid READ_LATENCY cycles after acceptance
- key_state  out  1  debounced level, 1 = pressed
- press_pulse  out  1  one-cycle pulse on debounced 0->1
- release_pulse  out  1  one-cycle pulse on debounced 1->0
- sample_strobe  out  1  one-cycle pulse each time a raw sample is captured

Behaviour:
- Reset (async, reset_n low): state IDLE, timer 0, avm_read 0, key_state 0, press_pulse/release_pulse/sample_strobe 0, debounce count 0, last-sample register 0 (not pressed). avm_address is always KEY_ADDR.
- Timer:
  - Counts 0..POLL_DIV-1 while poll_en=1, then wraps to 0.
  - Emits tick on the wrap cycle.
  - Holds its value while poll_en=0.
  - Keeps counting while a read is in flight.
  - A tick arriving outside IDLE is dropped, not queued.
- FSM:
  - IDLE: on tick -> REQ.
  - REQ: avm_read=1. Transfer is accepted on the first cycle with avm_waitrequest=0. On acceptance -> WAIT if READ_LATENCY>0, else capture readdata on the same cycle and -> IDLE. The request is held indefinitely while waitrequest=1; poll_en=0 does not abort an issued request.
  - WAIT: counts READ_LATENCY cycles from acceptance. On the last count, capture readdata[KEY_BIT] -> IDLE.
- Capture:
  - Raw pressed = readdata[KEY_BIT] XOR ACTIVE_LOW.
  - sample_strobe pulses on the capture cycle.
  - With READ_LATENCY=1, accepted at cycle T, data is sampled at T+1.
- Debounce:
  - If raw equals the last sample, count increments, saturating at DEBOUNCE_N. Otherwise count resets to 1 and the last sample updates.
  - When count reaches DEBOUNCE_N and raw differs from key_state, key_state updates on the cycle after capture.
  - The matching press_pulse or release_pulse is asserted for exactly that one cycle.
  - DEBOUNCE_N=1: every differing sample changes state.
- Minimum gap between reads is POLL_DIV cycles. If the read round trip exceeds POLL_DIV, polls are skipped silently.
- Reset mid-read: avm_read drops immediately (asynchronously); any in-flight capture is discarded.

Optional Feature:
- Macro KEY_POLL_IRQ_EN.
- Defined:
  - Adds ports irq (out, 1) and irq_ack (in, 1).
  - irq is set the cycle after press_pulse and held until irq_ack=1. The clear happens on the next edge.
  - Simultaneous press_pulse and irq_ack: set wins.
  - irq reset value is 0.
- Undefined: the ports are absent; no irq logic is built.

Decomposition:
- Shared package key_poll_pkg holds:
  - FSM state enum: IDLE, REQ, WAIT.
  - Width constants for the timer (24) and latency counter (3).
- One natural sub-module, key_debounce: contains the sample/count/level/pulse logic, driven by a sample strobe and raw bit, with DEBOUNCE_N parameter.
- The top contains the timer and the Avalon FSM.

Test Plan:
- POLL_DIV=10, READ_LATENCY=1, waitrequest=0, slave returns 1 (released) -> avm_read high 1 cycle every 10 cycles; key_state stays 0; no pulses.
- Slave switches to 0 (pressed), DEBOUNCE_N=4 -> press_pulse exactly once, the cycle after the 4th consecutive 0 sample; key_state=1 thereafter; returning to 1 gives release_pulse after 4 samples.
- Glitch: samples 0,0,1,0,0,0 with DEBOUNCE_N=4 -> no press_pulse until the 4th consecutive 0 after the 1.
- waitrequest held high 25 cycles with POLL_DIV=10 -> avm_read remains high the whole time, exactly one transfer, intervening ticks dropped; capture READ_LATENCY cycles after acceptance.
- reset_n pulsed low while in WAIT -> avm_read/outputs 0 immediately, no sample_strobe; polling resumes one POLL_DIV after release.
- KEY_POLL_IRQ_EN defined: press sets irq; irq_ack asserted on the same cycle as a second press_pulse -> irq remains 1; a later lone ack clears it.
